fl_rr_arbiter: RTL

- Frame-atomic round-robin arbiter that shares one FrameLink output channel between PORTS FrameLink input channels.
- Sits in front of a single FrameLink consumer (e.g. FL_TRANSFORMER or an output buffer) so that several producers can use it.
- Grants a port only at start of frame and holds the grant until that frame's EOF word is transferred; packets and frames are never interleaved.
- Exports the index of the currently forwarded port.

---
 rtl/fl_arb_pkg.sv | 23 ++
 rtl/fl_rr_pick.sv | 37 +++
 rtl/fl_rr_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fl_arb_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the FrameLink arbitration blocks: width helper,
// arbiter state type and the supported port-count ceiling.
package fl_arb_pkg;

    localparam int C_MAX_PORTS = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } t_arb_state;

    // Ceiling log2 with a floor of 1, so single-bit fields never collapse to zero width.
    function automatic int log2(input int n);
        int r;
        r = 32'sd1;
        while ((32'sd1 <<< r) < n) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fl_rr_pick.sv
`timescale 1ns/1ps
// Rotating priority encoder: returns the first requesting index found when
// scanning from ptr upward, wrapping from PORTS-1 back to 0.
module fl_rr_pick
    import fl_arb_pkg::*;
#(
    parameter int PORTS     = 4,
    parameter int SEL_WIDTH = log2(PORTS)
) (
    input  logic [PORTS-1:0]     req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] pick,
    output logic                 valid
);

    logic [SEL_WIDTH:0]   sum_s;
    logic [SEL_WIDTH-1:0] idx_s;
    logic                 hit_s;

    // Scan from farthest to nearest so the closest request to ptr wins last.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        sum_s = '0;
        idx_s = '0;
        hit_s = 1'b0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            sum_s = {1'b0, ptr} + (SEL_WIDTH + 1)'(k);
            sum_s = (sum_s >= (SEL_WIDTH + 1)'(PORTS)) ? (sum_s - (SEL_WIDTH + 1)'(PORTS)) : sum_s;
            idx_s = sum_s[SEL_WIDTH-1:0];
            hit_s = req[idx_s];
            pick  = hit_s ? idx_s : pick;
            valid = valid | hit_s;
        end
    end

endmodule

// File: rtl/fl_rr_arbiter.sv
`timescale 1ns/1ps
// FrameLink round-robin arbiter: grants a port only at SOF and holds it until
// that frame's EOF word has left on TX. Datapath is a zero-latency mux.
module fl_rr_arbiter
    import fl_arb_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int REM_WIDTH  = log2(DATA_WIDTH / 32'sd8),
    parameter int SEL_WIDTH  = log2(PORTS)
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [PORTS-1:0]              PORT_EN,
    input  logic [PORTS*DATA_WIDTH-1:0]   RX_DATA,
    input  logic [PORTS*REM_WIDTH-1:0]    RX_REM,
    input  logic [PORTS-1:0]              RX_SOF_N,
    input  logic [PORTS-1:0]              RX_EOF_N,
    input  logic [PORTS-1:0]              RX_SOP_N,
    input  logic [PORTS-1:0]              RX_EOP_N,
    input  logic [PORTS-1:0]              RX_SRC_RDY_N,
    output logic [PORTS-1:0]              RX_DST_RDY_N,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic [REM_WIDTH-1:0]          TX_REM,
    output logic                          TX_SOF_N,
    output logic                          TX_EOF_N,
    output logic                          TX_SOP_N,
    output logic                          TX_EOP_N,
    output logic                          TX_SRC_RDY_N,
    input  logic                          TX_DST_RDY_N,
    output logic [SEL_WIDTH-1:0]          TX_PORT
);

    t_arb_state           state_r, state_nxt_s;
    logic [SEL_WIDTH-1:0] ptr_r, ptr_nxt_s;
    logic [SEL_WIDTH-1:0] lock_sel_r, lock_sel_nxt_s;

    logic [PORTS-1:0]     req_s;
    logic [SEL_WIDTH-1:0] pick_s;
    logic                 pick_valid_s;
    logic [SEL_WIDTH-1:0] sel_s;
    logic [SEL_WIDTH-1:0] sel_inc_s;
    logic                 grant_s;
    logic [PORTS-1:0]     onehot_s;
    logic                 tx_xfer_s;

    // Only a port offering a valid SOF word may win a new grant.
    assign req_s = PORT_EN & ~RX_SRC_RDY_N & ~RX_SOF_N;

    fl_rr_pick #(
        .PORTS     (PORTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .req   (req_s),
        .ptr   (ptr_r),
        .pick  (pick_s),
        .valid (pick_valid_s)
    );

    // Select source: the locked port unconditionally, otherwise the live pick.
    always_comb begin
        sel_s   = '0;
        grant_s = 1'b0;
        if (state_r == LOCKED) begin
            sel_s   = lock_sel_r;
            grant_s = 1'b1;
        end else begin
            sel_s   = pick_s;
            grant_s = pick_valid_s;
        end
    end

    assign sel_inc_s = (sel_s == SEL_WIDTH'(PORTS - 1)) ? '0 : (sel_s + SEL_WIDTH'(1));

    // One-hot AND-OR mux of the selected RX channel onto TX.
    always_comb begin
        onehot_s = '0;
        TX_DATA  = '0;
        TX_REM   = '0;
        for (int i = 0; i < PORTS; i++) begin
            onehot_s[i] = (sel_s == SEL_WIDTH'(i));
            TX_DATA     = TX_DATA | ({DATA_WIDTH{onehot_s[i]}} & RX_DATA[i*DATA_WIDTH +: DATA_WIDTH]);
            TX_REM      = TX_REM | ({REM_WIDTH{onehot_s[i]}} & RX_REM[i*REM_WIDTH +: REM_WIDTH]);
        end
    end

    assign TX_SOF_N     = ~|(onehot_s & ~RX_SOF_N);
    assign TX_EOF_N     = ~|(onehot_s & ~RX_EOF_N);
    assign TX_SOP_N     = ~|(onehot_s & ~RX_SOP_N);
    assign TX_EOP_N     = ~|(onehot_s & ~RX_EOP_N);
    // Handshakes are held off while in reset so a truncated frame cannot leak through.
    assign TX_SRC_RDY_N = ~(RESET_N & grant_s & (|(onehot_s & ~RX_SRC_RDY_N)));
    assign RX_DST_RDY_N = ~({PORTS{RESET_N & grant_s & ~TX_DST_RDY_N}} & onehot_s);
    assign TX_PORT      = sel_s & {SEL_WIDTH{RESET_N}};
    assign tx_xfer_s    = ~TX_SRC_RDY_N & ~TX_DST_RDY_N;

    // Next-state: lock on a multi-word frame start, rotate ptr past the port at EOF.
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        lock_sel_nxt_s = lock_sel_r;
        case (state_r)
            IDLE: begin
                if (tx_xfer_s && (TX_EOF_N == 1'b0)) begin
                    ptr_nxt_s = sel_inc_s;
                end else if (tx_xfer_s) begin
                    state_nxt_s    = LOCKED;
                    lock_sel_nxt_s = sel_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (tx_xfer_s && (TX_EOF_N == 1'b0)) begin
                    state_nxt_s = IDLE;
                    ptr_nxt_s   = sel_inc_s;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Arbiter state, rotation pointer and locked port.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            lock_sel_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            lock_sel_r <= lock_sel_nxt_s;
        end
    end

endmodule
